// File: rtl/mod_accumulator_if.sv
// rtl/mod_accumulator_if.sv - config, input stream and result stream bundle for mod_accumulator
// slave  (accumulator side): cfg_load, cfg_k, in_valid, in_data, in_last, out_ready in;
//                            in_ready, out_valid, out_data, out_count, in_err out.
// master (producer/consumer side): the same signals with directions reversed.
interface mod_accumulator_if #(
  parameter int N_BITS = 12,
  parameter int CNT_W  = 8
);
  logic              cfg_load;
  logic [N_BITS-1:0] cfg_k;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              in_err;

  modport master (
    output cfg_load, cfg_k, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, in_err
  );

  modport slave (
    input  cfg_load, cfg_k, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, in_err
  );
endinterface

// File: rtl/mod_accumulator.sv
// rtl/mod_accumulator.sv - accumulates one (sum of beats) mod M result per frame
// Optional feature macro: RANGE_CHECK_EN (sticky in_err on operands >= M).
// Ports: clk            rising-edge clock
//        rst            synchronous, active-high reset
//        bus (slave)    cfg_load/cfg_k     load K = 2^N_BITS - M, abort frame
//                       in_valid/in_ready/in_data/in_last    operand stream
//                       out_valid/out_ready/out_data/out_count  per-frame result
//                       in_err             sticky range error (0 unless RANGE_CHECK_EN)

// Modular adder core: s = (a + b) mod M, M = 2^N - k.
// a + b >= M exactly when a + b + k carries out of N bits; in that case the
// low N bits of a + b + k are the reduced sum.
module mod_add_core #(
  parameter int N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic [N-1:0] s
);
  logic [N+1:0] ab;
  logic [N+1:0] abk;

  assign ab  = {2'b00, a} + {2'b00, b};
  assign abk = ab + {2'b00, k};
  assign s   = (abk[N+1:N] != 2'b00) ? abk[N-1:0] : ab[N-1:0];
endmodule

module mod_accumulator #(
  parameter int N_BITS = 12,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst,
  mod_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state;
  logic [N_BITS-1:0] k_reg;
  logic [N_BITS-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [N_BITS-1:0] out_data_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_valid_q;

  logic              in_ready;
  logic              accept;
  logic [N_BITS-1:0] b_op;
  logic [N_BITS-1:0] sum;
  logic [CNT_W-1:0]  cnt_inc;

  // DONE is the only state holding a result, so a stalled consumer blocks
  // input; a consuming one lets the next beat in on the same cycle.
  assign in_ready = !rst && !bus.cfg_load && (state != DONE || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef RANGE_CHECK_EN
  logic err_q;
  logic b_bad;

  // in_data >= M  <=>  in_data + K carries out of N_BITS
  assign b_bad      = (({1'b0, bus.in_data} + {1'b0, k_reg}) >> N_BITS) != '0;
  // An out-of-range beat still counts but contributes nothing to the sum.
  assign b_op       = b_bad ? '0 : bus.in_data;
  assign bus.in_err = err_q;
`else
  assign b_op       = bus.in_data;
  assign bus.in_err = 1'b0;
`endif

  mod_add_core #(.N(N_BITS)) u_core (
    .a (acc),
    .b (b_op),
    .k (k_reg),
    .s (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
`ifdef RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else if (bus.cfg_load) begin
      state       <= IDLE;
      k_reg       <= bus.cfg_k;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
`ifdef RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else if (accept) begin
`ifdef RANGE_CHECK_EN
      if (b_bad) begin
        err_q <= 1'b1;
      end
`endif
      if (bus.in_last) begin
        // Replaces any result handed over this same cycle: no bubble.
        out_data_q  <= sum;
        out_count_q <= cnt_inc;
        out_valid_q <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
        state       <= DONE;
      end else begin
        // Accepting while a result is pending implies out_ready was high.
        acc         <= sum;
        cnt         <= cnt_inc;
        out_valid_q <= 1'b0;
        state       <= ACC;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      state       <= IDLE;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_mod_accumulator.sv
// tb/tb_mod_accumulator.sv - randomized self-checking bench for mod_accumulator
module tb_mod_accumulator;
  localparam int N_BITS = 12;
  localparam int CNT_W  = 8;
  localparam int K_DEF  = 59;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_accumulator_if #(.N_BITS(N_BITS), .CNT_W(CNT_W)) bus ();

  mod_accumulator #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_acc_cyc = 0;
  bit rand_ready_en = 1'b0;

  logic [N_BITS-1:0] got_data_q[$];
  logic [CNT_W-1:0]  got_cnt_q[$];
  int                got_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !bus.cfg_load && bus.out_valid && bus.out_ready) begin
      got_data_q.push_back(bus.out_data);
      got_cnt_q.push_back(bus.out_count);
      got_cyc_q.push_back(cyc);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: whole-frame arithmetic, sum first then reduce.
  function automatic int unsigned ref_sum(input int unsigned vals[$], input int unsigned m);
    longint unsigned s = 0;
    foreach (vals[i]) s += vals[i];
    return 32'(s % m);
  endfunction

  function automatic int unsigned ref_count(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_data_q.delete();
    got_cnt_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic apply_cfg(input int k);
    bus.cfg_k    = N_BITS'(k);
    bus.cfg_load = 1'b1;
    step(1);
    bus.cfg_load = 1'b0;
  endtask

  task automatic send_beat(input int d, input logic l);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = N_BITS'(d);
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (got_data_q.size() < n && t < 400) begin
      step(1);
      t++;
    end
  endtask

  task automatic test_reset();
    step(1);
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_count, bus.in_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%0b vld=%0b data=%0d cnt=%0d err=%0b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_count, bus.in_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", bus.in_ready);
    end
    step(1);
  endtask

  task automatic test_basic();
    int unsigned vals[$];
    int unsigned m = 4096 - K_DEF;
    apply_cfg(K_DEF);
    bus.out_ready = 1'b1;
    clear_q();
    vals = '{420, 3000, 2000};
    foreach (vals[i]) send_beat(int'(vals[i]), i == vals.size() - 1);
    wait_results(1);
    vectors++;
    if (got_data_q.size() != 1) begin
      miscompares++;
      $display("FAIL basic_results: got %0d results, required 1", got_data_q.size());
    end else begin
      vectors += 3;
      if (got_data_q[0] !== N_BITS'(ref_sum(vals, m))) begin
        miscompares++;
        $display("FAIL basic_data: got %0d required %0d", got_data_q[0], ref_sum(vals, m));
      end
      if (got_cnt_q[0] !== CNT_W'(ref_count(vals.size()))) begin
        miscompares++;
        $display("FAIL basic_count: got %0d required %0d", got_cnt_q[0], vals.size());
      end
      if (got_cyc_q[0] != last_acc_cyc) begin
        miscompares++;
        $display("FAIL basic_latency: result in cycle %0d, required %0d", got_cyc_q[0], last_acc_cyc);
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned vals[$];
    int unsigned exp_d[$];
    int unsigned exp_c[$];
    clear_q();
    vals = '{4036, 4036};
    exp_d.push_back(ref_sum(vals, 4096 - K_DEF));
    exp_c.push_back(ref_count(2));
    send_beat(4036, 1'b0);
    send_beat(4036, 1'b1);
    wait_results(1);
    apply_cfg(0);
    vals = '{4095, 1};
    exp_d.push_back(ref_sum(vals, 4096));
    exp_c.push_back(ref_count(2));
    send_beat(4095, 1'b0);
    send_beat(1, 1'b1);
    wait_results(2);
    apply_cfg(K_DEF);
    vectors++;
    if (got_data_q.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_results: got %0d results, required 2", got_data_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors += 2;
        if (got_data_q[i] !== N_BITS'(exp_d[i])) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: got %0d required %0d", i, got_data_q[i], exp_d[i]);
        end
        if (got_cnt_q[i] !== CNT_W'(exp_c[i])) begin
          miscompares++;
          $display("FAIL wrap_count[%0d]: got %0d required %0d", i, got_cnt_q[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned vals[$];
    int unsigned hold;
    vals = '{420, 3000, 2000};
    hold = ref_sum(vals, 4096 - K_DEF);
    bus.out_ready = 1'b0;
    clear_q();
    foreach (vals[i]) send_beat(int'(vals[i]), i == vals.size() - 1);
    bus.in_valid = 1'b1;
    bus.in_data  = N_BITS'(7);
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_count} !== {1'b0, 1'b1, N_BITS'(hold), CNT_W'(3)}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: rdy=%0b vld=%0b data=%0d cnt=%0d, required rdy=0 vld=1 data=%0d cnt=3",
                 c, bus.in_ready, bus.out_valid, bus.out_data, bus.out_count, hold);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_beat(7, 1'b1);
    wait_results(2);
    vectors++;
    if (got_data_q.size() != 2) begin
      miscompares++;
      $display("FAIL stall_results: got %0d results, required 2", got_data_q.size());
    end else begin
      vectors++;
      if ({got_data_q[0], got_data_q[1], got_cnt_q[1]} !== {N_BITS'(hold), N_BITS'(7), CNT_W'(1)}) begin
        miscompares++;
        $display("FAIL stall_release: got %0d,%0d cnt %0d, required %0d,7 cnt 1",
                 got_data_q[0], got_data_q[1], got_cnt_q[1], hold);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned vals[$];
    vals = '{10, 20, 30};
    bus.out_ready = 1'b1;
    clear_q();
    foreach (vals[i]) send_beat(int'(vals[i]), 1'b1);
    wait_results(3);
    vectors++;
    if (got_data_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_results: got %0d results, required 3", got_data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if ({got_data_q[i], got_cnt_q[i]} !== {N_BITS'(vals[i]), CNT_W'(1)}) begin
          miscompares++;
          $display("FAIL b2b_out[%0d]: got %0d cnt %0d, required %0d cnt 1", i, got_data_q[i], got_cnt_q[i], vals[i]);
        end
        if (i > 0) begin
          vectors++;
          if (got_cyc_q[i] != got_cyc_q[i-1] + 1) begin
            miscompares++;
            $display("FAIL b2b_spacing[%0d]: gap %0d cycles, required 1", i, got_cyc_q[i] - got_cyc_q[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_cfg_abort();
    bus.out_ready = 1'b1;
    clear_q();
    send_beat(420, 1'b0);
    send_beat(3000, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = N_BITS'(999);
    bus.in_last  = 1'b1;
    bus.cfg_k    = N_BITS'(K_DEF);
    bus.cfg_load = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_blocks_input: in_ready=%0b required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    send_beat(5, 1'b1);
    wait_results(1);
    step(2);
    vectors++;
    if (got_data_q.size() != 1 || got_data_q[0] !== N_BITS'(5) || got_cnt_q[0] !== CNT_W'(1)) begin
      miscompares++;
      $display("FAIL cfg_abort: got %0d results first=%0d cnt=%0d, required 1 result 5 cnt 1",
               got_data_q.size(), (got_data_q.size() > 0) ? got_data_q[0] : 'x,
               (got_cnt_q.size() > 0) ? got_cnt_q[0] : 'x);
    end
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b0;
    send_beat(50, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: in_ready=%0b required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_count, bus.in_err} !== '0) begin
      miscompares++;
      $display("FAIL rst_done_outputs: vld=%0b data=%0d cnt=%0d err=%0b, required all 0",
               bus.out_valid, bus.out_data, bus.out_count, bus.in_err);
    end
    bus.out_ready = 1'b1;
    apply_cfg(K_DEF);
    send_beat(100, 1'b0);
    send_beat(200, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    apply_cfg(K_DEF);
    clear_q();
    send_beat(7, 1'b1);
    wait_results(1);
    vectors++;
    if (got_data_q.size() != 1 || got_data_q[0] !== N_BITS'(7) || got_cnt_q[0] !== CNT_W'(1)) begin
      miscompares++;
      $display("FAIL rst_midframe: got %0d results first=%0d, required 1 result 7 cnt 1",
               got_data_q.size(), (got_data_q.size() > 0) ? got_data_q[0] : 'x);
    end
  endtask

  task automatic test_range();
    int unsigned vals[$];
    int unsigned kept[$];
    int unsigned m = 4096 - K_DEF;
    logic exp_err;
    vals = '{100, 4040, 200};
    foreach (vals[i]) if (vals[i] < m) kept.push_back(vals[i]);
`ifdef RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.out_ready = 1'b1;
    clear_q();
    foreach (vals[i]) send_beat(int'(vals[i]), i == vals.size() - 1);
    wait_results(1);
    vectors += 2;
    if (bus.in_err !== exp_err) begin
      miscompares++;
      $display("FAIL range_err: in_err=%0b required %0b", bus.in_err, exp_err);
    end
    if (got_cnt_q.size() != 1 || got_cnt_q[0] !== CNT_W'(3)) begin
      miscompares++;
      $display("FAIL range_count: got %0d results cnt=%0d, required 1 result cnt 3",
               got_cnt_q.size(), (got_cnt_q.size() > 0) ? got_cnt_q[0] : 'x);
    end
`ifdef RANGE_CHECK_EN
    vectors++;
    if (got_data_q.size() != 1 || got_data_q[0] !== N_BITS'(ref_sum(kept, m))) begin
      miscompares++;
      $display("FAIL range_data: got %0d required %0d",
               (got_data_q.size() > 0) ? got_data_q[0] : 'x, ref_sum(kept, m));
    end
`endif
    apply_cfg(K_DEF);
    vectors++;
    if (bus.in_err !== 1'b0) begin
      miscompares++;
      $display("FAIL range_err_clear: in_err=%0b required 0", bus.in_err);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 2; round++) begin
      int unsigned k;
      int unsigned m;
      int unsigned exp_d[$];
      int unsigned exp_c[$];
      int nframes = 12;
      bus.out_ready = 1'b1;
      step(3);
      k = (round == 0) ? 0 : $urandom_range(1, 400);
      m = 4096 - k;
      apply_cfg(int'(k));
      clear_q();
      rand_ready_en = 1'b1;
      for (int f = 0; f < nframes; f++) begin
        int unsigned vals[$];
        int len = (round == 1 && f == 0) ? 300 : $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          int unsigned d = $urandom_range(0, m - 1);
          if ($urandom_range(0, 3) == 0) step(1);
          vals.push_back(d);
          send_beat(int'(d), b == len - 1);
        end
        exp_d.push_back(ref_sum(vals, m));
        exp_c.push_back(ref_count(len));
      end
      rand_ready_en = 1'b0;
      step(1);
      bus.out_ready = 1'b1;
      wait_results(nframes);
      vectors++;
      if (got_data_q.size() != nframes) begin
        miscompares++;
        $display("FAIL rand_results[%0d]: got %0d results, required %0d", round, got_data_q.size(), nframes);
      end else begin
        for (int i = 0; i < nframes; i++) begin
          vectors++;
          if ({got_data_q[i], got_cnt_q[i]} !== {N_BITS'(exp_d[i]), CNT_W'(exp_c[i])}) begin
            miscompares++;
            $display("FAIL rand_frame[%0d.%0d]: got %0d cnt %0d, required %0d cnt %0d (K=%0d)",
                     round, i, got_data_q[i], got_cnt_q[i], exp_d[i], exp_c[i], k);
          end
        end
      end
    end
  endtask

  initial begin
    bus.cfg_load  = 1'b0;
    bus.cfg_k     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_cfg_abort();
    test_rst_mid();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
